// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: expands one AXI AW/AR burst command into per-beat addresses,
// flagging illegal commands with SLVERR on every beat while still emitting len+1 beats.
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH = 4,
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8),
    localparam int LANE_W = MAX_SIZE > 0 ? MAX_SIZE : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ID_WIDTH-1:0]   cmd_id_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [1:0]            cmd_burst_i,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [ID_WIDTH-1:0]   beat_id_o,
    output logic [ADDR_WIDTH-1:0] beat_addr_o,
    output logic [LANE_W-1:0]     beat_lane_o,
    output logic [7:0]            beat_idx_o,
    output logic                  beat_last_o,
    output logic [1:0]            beat_resp_o,
    output logic                  busy_o
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam logic [AW:0] ONE = (AW + 1)'(1);
    logic [0:0]          state;
    logic [ID_WIDTH-1:0] id;
    logic [AW-1:0]       addr, lo, nxt, c_lo;
    logic [AW:0]         wb, sz, step, c_sz, c_wb, c_page;
    logic [7:0]          len, idx;
    logic [2:0]          size;
    logic [1:0]          burst, resp;
    logic                c_wrap_len, c_err, accept;

    assign beat_valid_o = state == BURST;
    assign busy_o       = state == BURST;
    assign beat_last_o  = state == BURST && idx == len;
    assign beat_id_o    = id;
    assign beat_addr_o  = addr;
    assign beat_idx_o   = idx;
    assign beat_resp_o  = resp;
    assign beat_lane_o  = MAX_SIZE > 0 ? addr[LANE_W-1:0] : '0;

    // One extra bit lets the wrap boundary compare survive a window ending at 2**AW.
    always_comb begin
        sz = ONE << size;
        step = {1'b0, addr} + sz;
        nxt = burst == 2'b00 ? addr
            : burst == 2'b10 ? (step == {1'b0, lo} + wb ? lo : step[AW-1:0])
            : AW'(({1'b0, addr} & ~(sz - ONE)) + sz);
        c_sz = ONE << cmd_size_i;
        c_wb = ((AW + 1)'(cmd_len_i) + ONE) << cmd_size_i;
        c_lo = cmd_addr_i & ~AW'(c_wb - ONE);
        c_page = ((AW + 1)'(cmd_addr_i[11:0]) & ~(c_sz - ONE)) + c_wb;
        c_wrap_len = cmd_len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
        c_err = cmd_burst_i == 2'b11 || int'(cmd_size_i) > MAX_SIZE
            || (cmd_burst_i == 2'b10 && (!c_wrap_len || (cmd_addr_i & AW'(c_sz - ONE)) != '0))
            || (cmd_burst_i == 2'b01 && c_page > (AW + 1)'(4096));
        cmd_ready_o = !rst_i && (state == IDLE || (beat_ready_i && beat_last_o));
        accept = cmd_valid_i && cmd_ready_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            id    <= '0;
            addr  <= '0;
            lo    <= '0;
            wb    <= '0;
            len   <= '0;
            idx   <= '0;
            size  <= '0;
            burst <= '0;
            resp  <= '0;
        end else if (accept) begin
            state <= BURST;
            id    <= cmd_id_i;
            addr  <= cmd_addr_i;
            lo    <= c_lo;
            wb    <= c_wb;
            len   <= cmd_len_i;
            idx   <= '0;
            size  <= cmd_size_i;
            burst <= cmd_burst_i;
            resp  <= c_err ? 2'b10 : 2'b00;
        end else if (beat_valid_o && beat_ready_i) begin
            if (beat_last_o) begin
                state <= IDLE;
            end else begin
                idx  <= idx + 8'd1;
                addr <= nxt;
            end
        end
    end
endmodule
